// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared constants for the iterative divider: FSM state encoding, handshake
// level constants and the default operand width / iteration count.
// Configuration macro seen by users of this package: DIV_SIGNED_EN.
// -----------------------------------------------------------------------------
package div_pkg;

   localparam int DIV_DATA_W = 32;
   // One quotient bit is produced per iteration.
   localparam int DIV_CYCLES = DIV_DATA_W;

   // FSM encoding kept as plain vectors so legacy tooling can trace it.
   localparam logic [1:0] DIV_FREE   = 2'b00;
   localparam logic [1:0] DIV_BYZERO = 2'b01;
   localparam logic [1:0] DIV_ON     = 2'b10;
   localparam logic [1:0] DIV_END    = 2'b11;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if
// Request/result bundle between the pipeline controller (master) and the
// divider (slave).
//   start      : request, held until ready is seen
//   annul      : abort an in-flight division
//   signed_div : 1 = signed operation (only honoured with DIV_SIGNED_EN)
//   opdata1/2  : dividend / divisor, sampled on acceptance
//   result     : {remainder, quotient}
//   ready      : result valid
// -----------------------------------------------------------------------------
interface div_if
   import div_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
);
   logic                  start;
   logic                  annul;
   logic                  signed_div;
   logic [DATA_W-1:0]     opdata1;
   logic [DATA_W-1:0]     opdata2;
   logic [2*DATA_W-1:0]   result;
   logic                  ready;

   modport master (
      output start, annul, signed_div, opdata1, opdata2,
      input  result, ready
   );

   modport slave (
      input  start, annul, signed_div, opdata1, opdata2,
      output result, ready
   );
endinterface

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring iteration.
//   rd_in   : {partial remainder, remaining dividend bits / quotient bits}
//   divisor : divisor magnitude
//   rd_out  : register value after shifting left and trial-subtracting
// -----------------------------------------------------------------------------
module div_step
   import div_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
)
(
   input  logic [2*DATA_W-1:0] rd_in,
   input  logic [DATA_W-1:0]   divisor,
   output logic [2*DATA_W-1:0] rd_out
);

   // The shifted remainder needs one extra bit: it can reach 2*divisor-1.
   logic [DATA_W:0]   partial;
   logic              fits;
   logic [DATA_W-1:0] diff;

   always_comb begin
      partial = rd_in[2*DATA_W-1:DATA_W-1];
      fits    = (partial >= {1'b0, divisor});
      // The difference is below the divisor, so the modulo-2^DATA_W result is exact.
      diff    = partial[DATA_W-1:0] - divisor;
      if (fits) begin
         rd_out = {diff, rd_in[DATA_W-2:0], 1'b1};
      end else begin
         rd_out = {partial[DATA_W-1:0], rd_in[DATA_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Multi-cycle radix-2 restoring divider for the execute stage. One quotient bit
// per cycle; latency DATA_W+2 for a nonzero divisor, 2 for a zero divisor.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : div_if.slave request/result bundle
// Configuration: define DIV_SIGNED_EN to compile in the signed path
// (magnitude conversion and sign fix-up); otherwise all divisions are unsigned
// and signed_div is ignored.
// -----------------------------------------------------------------------------
module div_unit
   import div_pkg::*;
#(
   parameter int DATA_W = DIV_DATA_W
)
(
   input  logic  clk,
   input  logic  rst,
   div_if.slave  bus
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [1:0]          state_q,    state_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic [2*DATA_W-1:0] rd_q,       rd_d;
   logic [DATA_W-1:0]   dvs_q,      dvs_d;
   logic                neg_quot_q, neg_quot_d;
   logic                neg_rem_q,  neg_rem_d;
   logic [2*DATA_W-1:0] result_q,   result_d;
   logic                ready_q,    ready_d;

   logic [2*DATA_W-1:0] step_out;
   logic                neg1, neg2;
   logic [DATA_W-1:0]   mag1, mag2;
   logic [DATA_W-1:0]   fix_quot, fix_rem;

   div_step #(.DATA_W(DATA_W)) u_step (
      .rd_in   (rd_q),
      .divisor (dvs_q),
      .rd_out  (step_out)
   );

`ifdef DIV_SIGNED_EN
   assign neg1     = bus.signed_div & bus.opdata1[DATA_W-1];
   assign neg2     = bus.signed_div & bus.opdata2[DATA_W-1];
   assign mag1     = neg1 ? -bus.opdata1 : bus.opdata1;
   assign mag2     = neg2 ? -bus.opdata2 : bus.opdata2;
   // Quotient negated when signs differ; remainder follows the dividend.
   assign fix_quot = neg_quot_q ? -rd_q[DATA_W-1:0] : rd_q[DATA_W-1:0];
   assign fix_rem  = neg_rem_q  ? -rd_q[2*DATA_W-1:DATA_W] : rd_q[2*DATA_W-1:DATA_W];
`else
   logic unused_sign;
   assign neg1        = 1'b0;
   assign neg2        = 1'b0;
   assign mag1        = bus.opdata1;
   assign mag2        = bus.opdata2;
   assign fix_quot    = rd_q[DATA_W-1:0];
   assign fix_rem     = rd_q[2*DATA_W-1:DATA_W];
   assign unused_sign = bus.signed_div ^ neg_quot_q ^ neg_rem_q;
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      dvs_d      = dvs_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      result_d   = result_q;
      ready_d    = ready_q;

      case (state_q)
         DIV_FREE: begin
            if (bus.start == DivStart && !bus.annul) begin
               if (bus.opdata2 == '0) begin
                  state_d = DIV_BYZERO;
               end else begin
                  rd_d       = {{DATA_W{1'b0}}, mag1};
                  dvs_d      = mag2;
                  neg_quot_d = neg1 ^ neg2;
                  neg_rem_d  = neg1;
                  cnt_d      = '0;
                  state_d    = DIV_ON;
               end
            end
         end
         DIV_BYZERO: begin
            result_d = '0;
            ready_d  = DivResultReady;
            state_d  = DIV_END;
         end
         DIV_ON: begin
            if (bus.annul || bus.start == DivStop) begin
               // Partial result is simply dropped; ready never rose.
               state_d = DIV_FREE;
            end else if (cnt_q != CNT_W'(DATA_W)) begin
               rd_d  = step_out;
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               result_d = {fix_rem, fix_quot};
               ready_d  = DivResultReady;
               state_d  = DIV_END;
            end
         end
         DIV_END: begin
            // annul is ignored here; only dropping start releases the unit.
            if (bus.start == DivStop) begin
               result_d = '0;
               ready_d  = DivResultNotReady;
               state_d  = DIV_FREE;
            end
         end
         default: state_d = DIV_FREE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
      if (rst) begin
         state_q    <= DIV_FREE;
         cnt_q      <= '0;
         rd_q       <= '0;
         dvs_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         result_q   <= '0;
         ready_q    <= DivResultNotReady;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         dvs_q      <= dvs_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         result_q   <= result_d;
         ready_q    <= ready_d;
      end
   end

   assign bus.result = result_q;
   assign bus.ready  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Directed self-checking bench for div_unit. Inputs change and outputs are
// observed on the falling clock edge. Signed expectations depend on whether
// DIV_SIGNED_EN is defined for the build.
// -----------------------------------------------------------------------------
module tb_div_unit;

   localparam int W = 32;

`ifdef DIV_SIGNED_EN
   localparam logic [2*W-1:0] EXP_NEG7_2 = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
   localparam logic [2*W-1:0] EXP_OVF    = {32'h0000_0000, 32'h8000_0000};
`else
   localparam logic [2*W-1:0] EXP_NEG7_2 = {32'h0000_0001, 32'h7FFF_FFFC};
   localparam logic [2*W-1:0] EXP_OVF    = {32'h8000_0000, 32'h0000_0000};
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   div_if #(.DATA_W(W)) bus ();

   div_unit #(.DATA_W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Called right after a falling edge: presents the request (cycle 0) and
   // returns the cycle number in which ready is first seen (-1 on timeout).
   // Operands are scrambled after cycle 0 since they are don't-care then.
   task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output int lat, output logic [2*W-1:0] res);
      lat = -1;
      res = '0;
      bus.start      = 1'b1;
      bus.annul      = 1'b0;
      bus.signed_div = sgn;
      bus.opdata1    = a;
      bus.opdata2    = b;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) begin
            bus.opdata1 = 32'hDEAD_BEEF;
            bus.opdata2 = 32'h0000_0000;
         end
         if (bus.ready === 1'b1) begin
            lat = k;
            res = bus.result;
            break;
         end
      end
   endtask

   // Drops start and returns the outputs one cycle later.
   task automatic release_div(output logic rdy, output logic [2*W-1:0] res);
      bus.start = 1'b0;
      @(negedge clk);
      rdy = bus.ready;
      res = bus.result;
   endtask

   task automatic test_reset;
      rst            = 1'b1;
      bus.start      = 1'b0;
      bus.annul      = 1'b0;
      bus.signed_div = 1'b0;
      bus.opdata1    = '0;
      bus.opdata2    = '0;
      repeat (2) @(negedge clk);
      n_assert++;
      if (bus.ready !== 1'b0 || bus.result !== '0) begin
         n_fail++;
         $display("FAIL reset_state: ready=%b result=%h, want ready=0 result=0", bus.ready, bus.result);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_unsigned;
      int lat;
      logic rdy;
      logic [2*W-1:0] res;
      do_div(32'd100, 32'd7, 1'b0, lat, res);
      n_assert++;
      if (lat !== 34) begin
         n_fail++;
         $display("FAIL u100_7_latency: got %0d, want 34", lat);
      end
      n_assert++;
      if (res !== {32'd2, 32'd14}) begin
         n_fail++;
         $display("FAIL u100_7_result: got %h, want %h", res, {32'd2, 32'd14});
      end
      // Held start keeps the result; annul in END must not disturb it.
      for (int i = 0; i < 3; i++) begin
         bus.annul = (i == 0);
         @(negedge clk);
         n_assert++;
         if (bus.ready !== 1'b1 || bus.result !== {32'd2, 32'd14}) begin
            n_fail++;
            $display("FAIL u100_7_hold%0d: ready=%b result=%h, want ready=1 result=%h",
                     i, bus.ready, bus.result, {32'd2, 32'd14});
         end
      end
      bus.annul = 1'b0;
      release_div(rdy, res);
      n_assert++;
      if (rdy !== 1'b0 || res !== '0) begin
         n_fail++;
         $display("FAIL u100_7_release: ready=%b result=%h, want ready=0 result=0", rdy, res);
      end
   endtask

   task automatic test_signed;
      int lat;
      logic rdy;
      logic [2*W-1:0] res;
      do_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, res);
      n_assert++;
      if (lat !== 34 || res !== EXP_NEG7_2) begin
         n_fail++;
         $display("FAIL s_neg7_2: lat=%0d result=%h, want lat=34 result=%h", lat, res, EXP_NEG7_2);
      end
      release_div(rdy, res);
      do_div(32'hFFFF_FFF9, 32'd2, 1'b0, lat, res);
      n_assert++;
      if (lat !== 34 || res !== {32'd1, 32'h7FFF_FFFC}) begin
         n_fail++;
         $display("FAIL u_fff9_2: lat=%0d result=%h, want lat=34 result=%h",
                  lat, res, {32'd1, 32'h7FFF_FFFC});
      end
      release_div(rdy, res);
      do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, res);
      n_assert++;
      if (lat !== 34 || res !== EXP_OVF) begin
         n_fail++;
         $display("FAIL s_most_neg_by_m1: lat=%0d result=%h, want lat=34 result=%h", lat, res, EXP_OVF);
      end
      release_div(rdy, res);
   endtask

   task automatic test_div_by_zero;
      int lat;
      logic rdy;
      logic [2*W-1:0] res;
      do_div(32'd12345, 32'd0, 1'b0, lat, res);
      n_assert++;
      if (lat !== 2 || res !== '0) begin
         n_fail++;
         $display("FAIL div_by_zero: lat=%0d result=%h, want lat=2 result=0", lat, res);
      end
      release_div(rdy, res);
      n_assert++;
      if (rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL div_by_zero_release: ready=%b, want 0", rdy);
      end
   endtask

   task automatic test_annul;
      int lat;
      int early = 0;
      logic rdy;
      logic [2*W-1:0] res;
      bus.start      = 1'b1;
      bus.annul      = 1'b0;
      bus.signed_div = 1'b0;
      bus.opdata1    = 32'd20;
      bus.opdata2    = 32'd4;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.ready !== 1'b0) early++;
      end
      bus.annul = 1'b1;
      @(negedge clk);
      bus.annul = 1'b0;
      if (bus.ready !== 1'b0) early++;
      n_assert++;
      if (early != 0) begin
         n_fail++;
         $display("FAIL annul_ready_low: ready seen high in %0d cycles, want 0", early);
      end
      // Cycle 11: unit is FREE, so the fresh request is taken right here.
      do_div(32'd9, 32'd3, 1'b0, lat, res);
      n_assert++;
      if (lat !== 34 || res !== {32'd0, 32'd3}) begin
         n_fail++;
         $display("FAIL annul_then_9_3: lat=%0d result=%h, want lat=34 result=%h",
                  lat, res, {32'd0, 32'd3});
      end
      release_div(rdy, res);
   endtask

   task automatic test_reset_mid;
      int lat;
      logic rdy;
      logic [2*W-1:0] res;
      bus.start      = 1'b1;
      bus.annul      = 1'b0;
      bus.signed_div = 1'b0;
      bus.opdata1    = 32'd1000;
      bus.opdata2    = 32'd3;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_assert++;
      if (bus.ready !== 1'b0 || bus.result !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_state: ready=%b result=%h, want ready=0 result=0", bus.ready, bus.result);
      end
      do_div(32'd1000, 32'd3, 1'b0, lat, res);
      n_assert++;
      if (lat !== 34 || res !== {32'd1, 32'd333}) begin
         n_fail++;
         $display("FAIL reset_mid_restart: lat=%0d result=%h, want lat=34 result=%h",
                  lat, res, {32'd1, 32'd333});
      end
      release_div(rdy, res);
   endtask

   task automatic test_back_to_back;
      int lat;
      logic rdy;
      logic [2*W-1:0] res;
      logic [W-1:0] a_tab [3] = '{32'd50, 32'hFFFF_FFFF, 32'd5};
      logic [W-1:0] b_tab [3] = '{32'd5,  32'd1,         32'd9};
      logic [2*W-1:0] e_tab [3] = '{{32'd0, 32'd10}, {32'd0, 32'hFFFF_FFFF}, {32'd5, 32'd0}};
      for (int i = 0; i < 3; i++) begin
         do_div(a_tab[i], b_tab[i], 1'b0, lat, res);
         n_assert++;
         if (lat !== 34 || res !== e_tab[i]) begin
            n_fail++;
            $display("FAIL back_to_back%0d: lat=%0d result=%h, want lat=34 result=%h",
                     i, lat, res, e_tab[i]);
         end
         release_div(rdy, res);
      end
   endtask

   initial begin
      test_reset;
      test_unsigned;
      test_signed;
      test_div_by_zero;
      test_annul;
      test_reset_mid;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
